// File: rtl/miner_work_scheduler.sv
// Work-unit sequencer for a bank of SHA-256d cores: loads work, sweeps the nonce range
// in interleaved strides, and funnels offset-corrected golden nonces into a FWFT FIFO.
module miner_work_scheduler #(
    parameter int NUM_HASHERS  = 4,
    parameter int PIPE_LATENCY = 64,
    parameter int NONCE_OFFSET = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      work_valid,
    output logic                      work_ready,
    input  logic [255:0]              work_midstate,
    input  logic [95:0]               work_data,
    input  logic [31:0]               work_nonce_start,
    output logic                      core_load,
    output logic [255:0]              core_midstate,
    output logic [95:0]               core_data,
    output logic                      core_enable,
    output logic [31:0]               core_nonce,
    input  logic [NUM_HASHERS-1:0]    hit,
    input  logic [32*NUM_HASHERS-1:0] hit_nonce,
    output logic                      golden_valid,
    input  logic                      golden_ready,
    output logic [31:0]               golden_nonce,
    output logic                      work_done,
    output logic                      hit_dropped
);
    localparam int IDX_W = (NUM_HASHERS > 1) ? $clog2(NUM_HASHERS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(PIPE_LATENCY + 1);
    localparam logic [31:0]      LOW_MASK   = 32'(NUM_HASHERS - 1);
    localparam logic [32:0]      STRIDE     = 33'(NUM_HASHERS);
    localparam logic [31:0]      OFFSET     = 32'(NONCE_OFFSET);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(PIPE_LATENCY - 1);
    localparam logic [CNT_W-1:0] BLANK_INIT = CNT_W'(PIPE_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HASH, S_DRAIN} state_t;

    state_t                  r_state, w_next;
    logic [255:0]            r_midstate;
    logic [95:0]             r_data;
    logic [31:0]             r_core_nonce;
    logic [CNT_W-1:0]        r_drain_cnt, r_blank_cnt;
    logic                    r_work_done, r_hit_dropped;
    logic [NUM_HASHERS-1:0]  r_pend;
    logic [31:0]             r_pend_nonce [NUM_HASHERS];
    logic [IDX_W-1:0]        r_rr;
    logic [31:0]             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr, r_rd;
    logic [PTR_W:0]          r_count;

    logic                    w_accept, w_abort, w_wrap, w_done_set, w_blanked;
    logic [32:0]             w_nonce_sum;
    logic                    w_pop, w_can_push, w_push, w_drop;
    logic [IDX_W-1:0]        w_grant_idx, w_cand;
    logic [NUM_HASHERS-1:0]  w_grant_vec, w_capture;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % NUM_HASHERS);
    endfunction

    assign w_accept    = work_valid & work_ready;
    assign w_abort     = w_accept & ((r_state == S_HASH) | (r_state == S_DRAIN));
    assign w_nonce_sum = {1'b0, r_core_nonce} + STRIDE;
    assign w_wrap      = w_nonce_sum[32];
    assign w_blanked   = (r_blank_cnt != '0);

    // NOTE: state register uses non-blocking assignment; all sequential state below does too.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_done_set  = 1'b0;
        work_ready  = (r_state != S_LOAD);
        core_load   = (r_state == S_LOAD);
        core_enable = (r_state == S_HASH);
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_LOAD;
            S_LOAD:  w_next = S_HASH;
            S_HASH:  if (w_accept) w_next = S_LOAD;
                     else if (w_wrap) w_next = S_DRAIN;
            S_DRAIN: if (w_accept) w_next = S_LOAD;
                     else if (r_drain_cnt == '0) begin
                         w_next     = S_IDLE;
                         w_done_set = 1'b1;
                     end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_midstate   <= '0;
            r_data       <= '0;
            r_core_nonce <= '0;
            r_drain_cnt  <= '0;
            r_blank_cnt  <= '0;
            r_work_done  <= 1'b0;
        end else begin
            r_work_done <= w_done_set;
            if (w_accept) begin
                r_midstate   <= work_midstate;
                r_data       <= work_data;
                r_core_nonce <= work_nonce_start & ~LOW_MASK;
            end else if (r_state == S_HASH) begin
                r_core_nonce <= w_nonce_sum[31:0];
            end
            if (r_state == S_HASH && w_wrap && !w_accept) r_drain_cnt <= DRAIN_INIT;
            else if (r_state == S_DRAIN && r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - CNT_ONE;
            // Hits still in flight from aborted work are masked for one pipeline length.
            if (w_abort) r_blank_cnt <= BLANK_INIT;
            else if (w_blanked) r_blank_cnt <= r_blank_cnt - CNT_ONE;
        end
    end

    assign w_pop      = golden_ready & (r_count != '0);
    assign w_can_push = (r_count != FIFO_FULL) | w_pop;

    always_comb begin
        w_push      = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        w_grant_vec = '0;
        for (int k = 0; k < NUM_HASHERS; k++) begin
            w_cand = wrap_idx(int'(r_rr) + k);
            if (w_can_push && !w_push && r_pend[w_cand]) begin
                w_push      = 1'b1;
                w_grant_idx = w_cand;
            end
        end
        if (w_push) w_grant_vec[w_grant_idx] = 1'b1;
    end

    // A re-hit on a core whose pending slot is being granted this cycle replaces it.
    always_comb begin
        w_capture = '0;
        w_drop    = 1'b0;
        for (int i = 0; i < NUM_HASHERS; i++) begin
            if (hit[i] && !w_blanked && !w_abort) begin
                if (r_pend[i] && !w_grant_vec[i]) w_drop = 1'b1;
                else                              w_capture[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend        <= '0;
            r_rr          <= '0;
            r_hit_dropped <= 1'b0;
            r_wr          <= '0;
            r_rd          <= '0;
            r_count       <= '0;
        end else begin
            if (w_abort) r_pend <= '0;
            else         r_pend <= (r_pend & ~w_grant_vec) | w_capture;
            if (w_push) begin
                r_rr <= wrap_idx(int'(w_grant_idx) + 1);
                r_wr <= r_wr + PTR_ONE;
            end
            if (w_pop) r_rd <= r_rd + PTR_ONE;
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
            if (w_accept)    r_hit_dropped <= 1'b0;
            else if (w_drop) r_hit_dropped <= 1'b1;
        end
    end

    // NOTE: data storage is not reset; valid flags and pointers alone define what is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_HASHERS; i++)
            if (w_capture[i]) r_pend_nonce[i] <= hit_nonce[32*i +: 32] - OFFSET;
        if (w_push) r_mem[r_wr] <= r_pend_nonce[w_grant_idx];
    end

    assign core_midstate = r_midstate;
    assign core_data     = r_data;
    assign core_nonce    = r_core_nonce;
    assign golden_valid  = (r_count != '0);
    assign golden_nonce  = r_mem[r_rd];
    assign work_done     = r_work_done;
    assign hit_dropped   = r_hit_dropped;
endmodule

// File: tb/tb_miner_work_scheduler.sv
// Self-checking bench for miner_work_scheduler: vector table for work loading,
// directed multi-cycle sequences, and randomized hits against a queue-based model.
module tb_miner_work_scheduler;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = 64;

    logic           clk, reset, work_valid, work_ready;
    logic [255:0]   work_midstate, core_midstate;
    logic [95:0]    work_data, core_data;
    logic [31:0]    work_nonce_start, core_nonce, golden_nonce;
    logic           core_load, core_enable, golden_valid, golden_ready, work_done, hit_dropped;
    logic [N-1:0]   hit;
    logic [32*N-1:0] hit_nonce;

    int n_chk = 0;
    int n_err = 0;

    miner_work_scheduler #(.NUM_HASHERS(N), .PIPE_LATENCY(LAT), .NONCE_OFFSET(3), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .work_valid(work_valid), .work_ready(work_ready),
        .work_midstate(work_midstate), .work_data(work_data), .work_nonce_start(work_nonce_start),
        .core_load(core_load), .core_midstate(core_midstate), .core_data(core_data),
        .core_enable(core_enable), .core_nonce(core_nonce), .hit(hit), .hit_nonce(hit_nonce),
        .golden_valid(golden_valid), .golden_ready(golden_ready), .golden_nonce(golden_nonce),
        .work_done(work_done), .hit_dropped(hit_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] mid;
        logic [95:0]  data;
        logic [31:0]  start;
        logic [31:0]  e0, e1, e2;
    } vec_t;
    vec_t vecs[3];

    // Behavioural model of hit collection, round-robin arbitration and the golden FIFO.
    bit          m_pend[N];
    logic [31:0] m_pn[N];
    int          m_rr;
    logic [31:0] m_q[$];
    bit          m_drop;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; work_valid = 1'b0; hit = '0; hit_nonce = '0; golden_ready = 1'b0;
        work_midstate = '0; work_data = '0; work_nonce_start = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic offer_work(input logic [255:0] mid, input logic [95:0] data, input logic [31:0] start);
        work_valid = 1'b1; work_midstate = mid; work_data = data; work_nonce_start = start;
        tick();
        work_valid = 1'b0;
    endtask

    task automatic pulse_hit(input int core, input logic [31:0] n);
        hit = '0; hit_nonce = '0;
        hit[core] = 1'b1;
        hit_nonce[32*core +: 32] = n;
        tick();
        hit = '0; hit_nonce = '0;
    endtask

    task automatic four_hits(input string tag, input logic [31:0] x0, input logic [31:0] x1,
                             input logic [31:0] x2, input logic [31:0] x3);
        logic [31:0] exp_q[4];
        exp_q[0] = x0; exp_q[1] = x1; exp_q[2] = x2; exp_q[3] = x3;
        golden_ready = 1'b1;
        hit = '1;
        hit_nonce = {32'd106, 32'd105, 32'd104, 32'd103};
        tick();
        hit = '0; hit_nonce = '0;
        check({tag, "_lat1_valid"}, golden_valid, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check({tag, "_valid"}, golden_valid, 1'b1);
            check({tag, "_order"}, golden_nonce, exp_q[k]);
            tick();
        end
        check({tag, "_empty"}, golden_valid, 1'b0);
        golden_ready = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_rr = 0; m_q.delete(); m_drop = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] h, input logic [32*N-1:0] hn, input logic rdy);
        bit pop;
        int grant;
        pop = rdy && (m_q.size() > 0);
        grant = -1;
        if (m_q.size() < DEPTH || pop)
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (grant < 0 && m_pend[idx]) grant = idx;
            end
        if (pop) void'(m_q.pop_front());
        if (grant >= 0) begin
            m_q.push_back(m_pn[grant]);
            m_pend[grant] = 1'b0;
            m_rr = (grant + 1) % N;
        end
        for (int i = 0; i < N; i++)
            if (h[i]) begin
                if (m_pend[i]) m_drop = 1'b1;
                else begin
                    m_pend[i] = 1'b1;
                    m_pn[i] = hn[32*i +: 32] - 32'd3;
                end
            end
    endtask

    initial begin
        vecs[0] = '{256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0,
                    96'h111111112222222233333333, 32'h00000003,
                    32'h00000000, 32'h00000004, 32'h00000008};
        vecs[1] = '{256'hdeadbeef_cafef00d_01010101_20202020_33333333_44444444_55555555_66666666,
                    96'habcdef01_23456789_0badf00d, 32'h7fffffff,
                    32'h7ffffffc, 32'h80000000, 32'h80000004};
        vecs[2] = '{256'h85a24391_1a2b3c4d_5e6f7081_92a3b4c5_d6e7f809_1a2b3c4d_5e6f7081_8b3f07ef,
                    96'hc513051a_02a99050_bfec0373, 32'h1afda094,
                    32'h1afda094, 32'h1afda098, 32'h1afda09c};

        do_reset();
        check("rst_ready", work_ready, 1'b1);
        check("rst_load", core_load, 1'b0);
        check("rst_enable", core_enable, 1'b0);
        check("rst_nonce", core_nonce, 32'h0);
        check("rst_mid", core_midstate, 256'h0);
        check("rst_golden_valid", golden_valid, 1'b0);
        check("rst_done", work_done, 1'b0);
        check("rst_dropped", hit_dropped, 1'b0);

        for (int v = 0; v < 3; v++) begin
            do_reset();
            offer_work(vecs[v].mid, vecs[v].data, vecs[v].start);
            check("vec_load", core_load, 1'b1);
            check("vec_ready_in_load", work_ready, 1'b0);
            check("vec_mid", core_midstate, vecs[v].mid);
            check("vec_data", core_data, vecs[v].data);
            check("vec_n_load", core_nonce, vecs[v].e0);
            tick();
            check("vec_load_off", core_load, 1'b0);
            check("vec_enable", core_enable, 1'b1);
            check("vec_n0", core_nonce, vecs[v].e0);
            tick();
            check("vec_n1", core_nonce, vecs[v].e1);
            tick();
            check("vec_n2", core_nonce, vecs[v].e2);
        end

        pulse_hit(1, 32'h1afda09c);
        check("hit_lat1_valid", golden_valid, 1'b0);
        tick();
        check("hit_lat2_valid", golden_valid, 1'b1);
        check("hit_nonce_fix", golden_nonce, 32'h1afda099);
        golden_ready = 1'b1;
        tick();
        check("hit_popped", golden_valid, 1'b0);
        four_hits("rr2", 32'd102, 32'd103, 32'd100, 32'd101);
        do_reset();
        four_hits("rr0", 32'd100, 32'd101, 32'd102, 32'd103);

        do_reset();
        pulse_hit(0, 32'h1000);
        pulse_hit(1, 32'h2000);
        pulse_hit(2, 32'h3000);
        pulse_hit(3, 32'h4000);
        pulse_hit(0, 32'h5000);
        check("bp_no_drop_yet", hit_dropped, 1'b0);
        pulse_hit(0, 32'h6000);
        check("bp_dropped", hit_dropped, 1'b1);
        tick();
        check("bp_held_head", golden_nonce, 32'h0ffd);
        golden_ready = 1'b1;
        begin
            logic [31:0] bp_exp[5];
            bp_exp[0] = 32'h0ffd; bp_exp[1] = 32'h1ffd; bp_exp[2] = 32'h2ffd;
            bp_exp[3] = 32'h3ffd; bp_exp[4] = 32'h4ffd;
            for (int k = 0; k < 5; k++) begin
                check("bp_valid", golden_valid, 1'b1);
                check("bp_order", golden_nonce, bp_exp[k]);
                tick();
            end
        end
        check("bp_empty", golden_valid, 1'b0);
        check("bp_sticky", hit_dropped, 1'b1);
        golden_ready = 1'b0;
        offer_work('0, '0, 32'h0);
        check("bp_clear_on_work", hit_dropped, 1'b0);

        do_reset();
        offer_work('0, '0, 32'hfffffff8);
        tick();
        check("wrap_n0", core_nonce, 32'hfffffff8);
        check("wrap_en0", core_enable, 1'b1);
        tick();
        check("wrap_n1", core_nonce, 32'hfffffffc);
        tick();
        check("wrap_zero", core_nonce, 32'h0);
        check("wrap_drain_en", core_enable, 1'b0);
        check("wrap_drain_done", work_done, 1'b0);
        begin
            int waited;
            waited = 0;
            for (int c = 1; c <= 200; c++) begin
                tick();
                if (work_done) begin
                    waited = c;
                    break;
                end
            end
            check("drain_len", waited, LAT);
        end
        tick();
        check("done_one_cycle", work_done, 1'b0);
        check("idle_ready", work_ready, 1'b1);
        check("idle_enable", core_enable, 1'b0);

        do_reset();
        offer_work('0, '0, 32'h100);
        tick();
        pulse_hit(2, 32'h55);
        tick();
        check("abort_pre_valid", golden_valid, 1'b1);
        offer_work('1, '1, 32'h1000);
        check("abort_load", core_load, 1'b1);
        check("abort_nonce", core_nonce, 32'h1000);
        begin
            bit done_seen;
            done_seen = 1'b0;
            for (int t = 0; t <= 70; t++) begin
                if (t == 0)  begin hit[3] = 1'b1; hit_nonce[127:96] = 32'h77; end
                if (t == 63) begin hit[3] = 1'b1; hit_nonce[127:96] = 32'h88; end
                if (t == 64) begin hit[1] = 1'b1; hit_nonce[63:32]  = 32'h99; end
                tick();
                hit = '0; hit_nonce = '0;
                done_seen |= work_done;
            end
            check("abort_no_done", done_seen, 1'b0);
        end
        check("abort_keep_valid", golden_valid, 1'b1);
        check("abort_keep_head", golden_nonce, 32'h52);
        golden_ready = 1'b1;
        tick();
        check("blank_end_valid", golden_valid, 1'b1);
        check("blank_end_head", golden_nonce, 32'h96);
        tick();
        check("abort_empty", golden_valid, 1'b0);

        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < N; i++) begin
                hit[i] = ($urandom_range(0, 3) == 0);
                hit_nonce[32*i +: 32] = $urandom;
            end
            golden_ready = $urandom_range(0, 1) == 1;
            model_step(hit, hit_nonce, golden_ready);
            tick();
            check("rnd_valid", golden_valid, m_q.size() > 0);
            if (m_q.size() > 0) check("rnd_nonce", golden_nonce, m_q[0]);
            check("rnd_drop", hit_dropped, m_drop);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/miner_work_scheduler.md
Name: miner_work_scheduler

Overview:
Sequences a bank of NUM_HASHERS identical SHA-256d hasher cores from one work unit (midstate, 96-bit data tail, start nonce). It loads the cores, sweeps the nonce space in interleaved strides and detects range exhaustion. It collects golden-nonce hits from all cores, corrects them for pipeline offset and arbitrates them round-robin into a FIFO feeding the serial transmitter. It sits between the serial receive/transmit logic and the hasher array inside fpgaminer_top.

Parameters:
NUM_HASHERS, 4, number of hasher cores (power of two, 1..16)
PIPE_LATENCY, 64, cycles from core nonce issue to possible hit report; sets drain and blanking length
NONCE_OFFSET, 3, value subtracted (mod 2^32) from a reported core nonce to get the true golden nonce
FIFO_DEPTH, 4, golden-nonce FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
work_valid  in  1  new work offered
work_ready  out  1  work accepted this cycle when valid&ready
work_midstate  in  256  midstate of new work
work_data  in  96  data tail of new work
work_nonce_start  in  32  first nonce; low log2(NUM_HASHERS) bits ignored (treated 0)
core_load  out  1  one-cycle pulse: cores latch midstate/data
core_midstate  out  256  registered midstate to cores
core_data  out  96  registered data to cores
core_enable  out  1  cores advance when high
core_nonce  out  32  base nonce; core i hashes core_nonce+i
hit  in  NUM_HASHERS  per-core golden-hit strobe
hit_nonce  in  32*NUM_HASHERS  per-core reported nonce, core i at bits [32i+31:32i]
golden_valid  out  1  FIFO not empty
golden_ready  in  1  transmitter pops head
golden_nonce  out  32  FIFO head
work_done  out  1  one-cycle pulse: range exhausted and drained
hit_dropped  out  1  sticky; cleared by reset or next accepted work

Behaviour:
- Reset values: state IDLE; core_load=0; core_enable=0; core_nonce=0; core_midstate=0; core_data=0; FIFO empty; golden_valid=0; work_done=0; hit_dropped=0; all pending bits 0; round-robin pointer=0; blanking counter=0.
- work_ready=1 in every state except LOAD.
- FSM states:
  - IDLE: on accept, go to LOAD.
  - LOAD, 1 cycle: core_load=1; core_midstate and core_data already registered at accept; core_nonce = start with low bits cleared; go to HASH.
  - HASH: core_enable=1; core_nonce += NUM_HASHERS each cycle. When the add carries out of bit 31, core_nonce wraps to 0 and the state goes to DRAIN with the drain counter = PIPE_LATENCY-1.
  - DRAIN: core_enable=0; hits still collected; counter reaches 0 -> IDLE, with a work_done pulse on that transition.
- Work accepted in HASH or DRAIN aborts the current work: go to LOAD, clear all pending bits, load blanking counter = PIPE_LATENCY. Hits are ignored while the blanking counter is nonzero (decrements each cycle). FIFO contents are retained. work_done is not pulsed.
- Hit capture:
  - A hit[i] not blanked sets pend[i] and latches pend_nonce[i] = hit_nonce[i] - NONCE_OFFSET (32-bit wrap).
  - If pend[i] is already set and not granted in the same cycle, the new hit is discarded and hit_dropped=1.
- Arbitration: each cycle, if the FIFO is not full (or is full with a pop in the same cycle), grant the first set pend bit at or after the rr pointer. The granted entry is pushed, its pend bit is cleared, and the pointer moves to the granted index+1 mod NUM_HASHERS. At most one push per cycle.
- Same-cycle grant and new hit on the same core: clear, then set; the new nonce is kept.
- FIFO:
  - First-word-fall-through; golden_nonce is valid whenever golden_valid=1.
  - Push and pop in the same cycle while full is allowed.
  - Pop when empty is ignored.
  - Latency from hit to golden_valid: 2 cycles (capture, then push).
- Full FIFO applies backpressure: pend bits hold and are never lost unless a core re-hits.
- Reset mid-operation returns everything to reset values within one cycle.

Test Plan:
- Reset, offer work midstate=85a24391..8b3f07ef, data=...c513051a02a99050bfec0373, start=1afda094 -> core_load pulse 1 cycle after accept; core_nonce=1afda094, then 1afda098, 1afda09c on successive cycles with core_enable=1.
- In HASH, hit[1]=1 with hit_nonce=1afda09c (NONCE_OFFSET=3) -> golden_valid 2 cycles later, golden_nonce=1afda099.
- All four hits in one cycle with nonces 103..106, golden_ready=1 -> pops 100,101,102,103 in core order on consecutive cycles. Repeat with pointer=2 -> order 102,103,100,101.
- golden_ready=0, six hits on distinct cycles from cores 0..3 then core 0 again while pend[0] is held -> FIFO holds 4, hit_dropped=1, nothing lost except the re-hit. Raise golden_ready -> remaining pended entry delivered.
- start=FFFFFFF8 -> two HASH cycles; core_nonce wraps to 0 and the FSM enters DRAIN. work_done pulses exactly PIPE_LATENCY cycles later; state IDLE.
- New work accepted mid-HASH while a hit arrives within PIPE_LATENCY cycles of the accept -> hit ignored, earlier FIFO entries still delivered, no work_done.
